// File: rtl/mult_control.sv
// mult_control -- sequencer for a shift-and-add multiplier datapath.
// One Moore FSM walks LOAD -> (CHECK -> [ADD] -> SHIFT) x WIDTH -> DONE,
// with a shift counter reported on Cnt.
// Optional build macro MULT_CTRL_DONE_HOLD_EN: DONE is held until Ack.
module mult_control #(
   parameter int WIDTH = 8
) (
   input  logic                     Clk,
   input  logic                     rst,
   input  logic                     St,
   input  logic                     LSB,
   input  logic                     Ack,
   output logic                     Load,
   output logic                     Ad,
   output logic                     Sh,
   output logic                     Done,
   output logic                     Busy,
   output logic [$clog2(WIDTH):0]   Cnt
);

   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      CHECK = 3'd2,
      ADD   = 3'd3,
      SHIFT = 3'd4,
      DONE  = 3'd5
   } state_t;

   state_t          state_reg, state_next;
   logic [CW-1:0]   cnt_reg, cnt_next;
   logic [CW-1:0]   cnt_inc;
   logic            last_shift;

   assign cnt_inc    = cnt_reg + CW'(1);
   assign last_shift = (cnt_inc == CW'(WIDTH));

`ifndef MULT_CTRL_DONE_HOLD_EN
   // Ack has no role when DONE is a single-cycle pulse.
   logic unused_ack;
   assign unused_ack = Ack;
`endif

   // State and shift-count registers; reset forces IDLE with a cleared count.
   always_ff @(posedge Clk or negedge rst) begin
      if (!rst) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   // Next-state and next-count: the count is cleared on the way into LOAD
   // and advanced by every SHIFT, so it never passes WIDTH.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      unique case (state_reg)
         IDLE: begin
            if (St) begin
               state_next = LOAD;
               cnt_next   = '0;
            end
         end
         LOAD:  state_next = CHECK;
         CHECK: state_next = LSB ? ADD : SHIFT;
         ADD:   state_next = SHIFT;
         SHIFT: begin
            cnt_next   = cnt_inc;
            state_next = last_shift ? DONE : CHECK;
         end
         DONE: begin
`ifdef MULT_CTRL_DONE_HOLD_EN
            if (Ack) state_next = IDLE;
`else
            state_next = IDLE;
`endif
         end
         default: state_next = IDLE;
      endcase
   end

   // Moore outputs decoded purely from the registered state and count.
   always_comb begin
      Load = (state_reg == LOAD);
      Ad   = (state_reg == ADD);
      Sh   = (state_reg == SHIFT);
      Done = (state_reg == DONE);
      Busy = (state_reg != IDLE);
      Cnt  = cnt_reg;
   end

endmodule

// File: tb/tb_mult_control.sv
// tb_mult_control -- directed bench for mult_control at WIDTH 8, 2 and 32.
// A small multiplier-register model feeds LSB back from Load/Sh.
// Honours MULT_CTRL_DONE_HOLD_EN when the build defines it.
module tb_mult_control;

   logic        Clk;
   logic        rst;
   logic        st   [3];
   logic        ack  [3];
   logic        lsb  [3];
   logic        load [3];
   logic        ad   [3];
   logic        sh   [3];
   logic        done [3];
   logic        busy [3];
   logic [5:0]  cnt  [3];
   logic [31:0] mreg [3];
   logic [31:0] mult_val [3];

   logic [3:0]  cnt8;
   logic [1:0]  cnt2;
   logic [5:0]  cnt32;

   int checks = 0;
   int errors = 0;

   mult_control #(.WIDTH(8)) u_w8 (
      .Clk(Clk), .rst(rst), .St(st[0]), .LSB(lsb[0]), .Ack(ack[0]),
      .Load(load[0]), .Ad(ad[0]), .Sh(sh[0]), .Done(done[0]), .Busy(busy[0]),
      .Cnt(cnt8));
   mult_control #(.WIDTH(2)) u_w2 (
      .Clk(Clk), .rst(rst), .St(st[1]), .LSB(lsb[1]), .Ack(ack[1]),
      .Load(load[1]), .Ad(ad[1]), .Sh(sh[1]), .Done(done[1]), .Busy(busy[1]),
      .Cnt(cnt2));
   mult_control #(.WIDTH(32)) u_w32 (
      .Clk(Clk), .rst(rst), .St(st[2]), .LSB(lsb[2]), .Ack(ack[2]),
      .Load(load[2]), .Ad(ad[2]), .Sh(sh[2]), .Done(done[2]), .Busy(busy[2]),
      .Cnt(cnt32));

   assign cnt[0] = {2'b00, cnt8};
   assign cnt[1] = {4'b0000, cnt2};
   assign cnt[2] = cnt32;

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Multiplier register of the datapath: loaded on Load, shifted right on Sh.
   always @(posedge Clk) begin
      for (int i = 0; i < 3; i++) begin
         if (load[i])    mreg[i] <= mult_val[i];
         else if (sh[i]) mreg[i] <= mreg[i] >> 1;
      end
   end

   always_comb begin
      for (int i = 0; i < 3; i++) lsb[i] = mreg[i][0];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   typedef struct {
      int          idx;
      int          w;
      logic [31:0] mv;
      int          exp_done;
      logic [31:0] exp_mask;
      int          repulse;
   } vec_t;

   vec_t vecs [9];

   // One full multiply; cycle 1 is the LOAD cycle after the edge sampling St.
   task automatic run_vec(input int vn, input vec_t v);
      int nl = 0, na = 0, nsh = 0, ovl = 0, dc = -1, extra = 0;
      logic [31:0] mask = '0;
      logic [5:0]  cad = '0;
      logic        busy_at_done = 1'b0;
      mult_val[v.idx] = v.mv;
      @(negedge Clk);
      st[v.idx] = 1'b1;
      @(posedge Clk);
      for (int cyc = 1; cyc <= 200; cyc++) begin
         @(negedge Clk);
         st[v.idx] = (v.repulse >= 0) && sh[v.idx] && (nsh == v.repulse);
         if ((ad[v.idx] && sh[v.idx]) || (load[v.idx] && (ad[v.idx] || sh[v.idx]))) ovl++;
         if (load[v.idx]) nl++;
         if (ad[v.idx]) begin
            na++;
            mask = mask | (32'd1 << nsh);
         end
         if (sh[v.idx]) nsh++;
         if (done[v.idx]) begin
            dc = cyc;
            cad = cnt[v.idx];
            busy_at_done = busy[v.idx];
            break;
         end
      end
      st[v.idx] = 1'b0;
      chk($sformatf("v%0d done_cycle", vn), dc, v.exp_done);
      chk($sformatf("v%0d ad_bits", vn), mask, v.exp_mask);
      chk($sformatf("v%0d sh_count", vn), nsh, v.w);
      chk($sformatf("v%0d load_count", vn), nl, 1);
      chk($sformatf("v%0d overlap", vn), ovl, 0);
      chk($sformatf("v%0d cnt_at_done", vn), 32'(cad), v.w);
      chk($sformatf("v%0d busy_at_done", vn), 32'(busy_at_done), 1);
      @(negedge Clk);
      chk($sformatf("v%0d done_falls", vn), 32'(done[v.idx]), 0);
      chk($sformatf("v%0d busy_falls", vn), 32'(busy[v.idx]), 0);
      chk($sformatf("v%0d cnt_held", vn), 32'(cnt[v.idx]), v.w);
      for (int k = 0; k < 6; k++) begin
         @(negedge Clk);
         if (load[v.idx] || done[v.idx] || busy[v.idx]) extra++;
      end
      chk($sformatf("v%0d no_extra_op", vn), extra, 0);
      $display("vec %0d w=%0d mv=%0h done_cycle=%0d ad=%0d", vn, v.w, v.mv, dc, na);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int found, bad, c_done, c_load, c_busy0, c_done2, dcount, c_fall, c_load2;
      vecs[0] = '{0, 8,  32'h05,       20, 32'h05,       -1};
      vecs[1] = '{0, 8,  32'h00,       18, 32'h00,       -1};
      vecs[2] = '{0, 8,  32'hFF,       26, 32'hFF,       -1};
      vecs[3] = '{0, 8,  32'hA6,       22, 32'hA6,       -1};
      vecs[4] = '{0, 8,  32'h05,       20, 32'h05,        3};
      vecs[5] = '{1, 2,  32'h2,         7, 32'h2,        -1};
      vecs[6] = '{1, 2,  32'h3,         8, 32'h3,        -1};
      vecs[7] = '{2, 32, 32'h9E3779B9, 86, 32'h9E3779B9, -1};
      vecs[8] = '{2, 32, 32'h0,        66, 32'h0,        -1};

      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         st[i] = 1'b0;
         mult_val[i] = '0;
`ifdef MULT_CTRL_DONE_HOLD_EN
         ack[i] = 1'b1;
`else
         ack[i] = 1'b0;
`endif
      end
      #1;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("rst%0d outs", i),
             {27'd0, load[i], ad[i], sh[i], done[i], busy[i]}, 32'd0);
         chk($sformatf("rst%0d cnt", i), 32'(cnt[i]), 0);
      end
      repeat (2) @(negedge Clk);
      rst = 1'b1;
      @(negedge Clk);
      chk("post_rst busy", 32'(busy[0]), 0);

      for (int n = 0; n < 9; n++) run_vec(n, vecs[n]);

      // Asynchronous reset in the middle of the ADD for bit 4.
      mult_val[0] = 32'h10;
      @(negedge Clk);
      st[0] = 1'b1;
      @(negedge Clk);
      st[0] = 1'b0;
      found = 0;
      for (int cyc = 0; cyc < 40 && found == 0; cyc++) begin
         @(negedge Clk);
         if (ad[0] && cnt[0] == 6'd4) found = 1;
      end
      chk("rst_mid reached_add4", found, 1);
      #2;
      rst = 1'b0;
      #1;
      chk("rst_mid outs", {27'd0, load[0], ad[0], sh[0], done[0], busy[0]}, 32'd0);
      chk("rst_mid cnt", 32'(cnt[0]), 0);
      @(negedge Clk);
      rst = 1'b1;
      bad = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge Clk);
         if (done[0] || busy[0] || load[0]) bad++;
      end
      chk("rst_mid no_done_after", bad, 0);
      $display("seq rst_mid add4 found=%0d activity_after=%0d", found, bad);

      // St held high: back-to-back multiplies with one IDLE cycle between.
      mult_val[0] = 32'h00;
      @(negedge Clk);
      st[0] = 1'b1;
      @(posedge Clk);
      c_done = -1; c_busy0 = -1; c_load = -1; c_done2 = -1;
      for (int cyc = 1; cyc <= 60 && c_done2 < 0; cyc++) begin
         @(negedge Clk);
         if (done[0] && c_done < 0) c_done = cyc;
         else if (c_done > 0 && !busy[0] && c_busy0 < 0) c_busy0 = cyc;
         else if (c_busy0 > 0 && load[0] && c_load < 0) c_load = cyc;
         else if (c_load > 0 && done[0] && c_done2 < 0) c_done2 = cyc;
      end
      st[0] = 1'b0;
      chk("b2b done1", c_done, 18);
      chk("b2b idle", c_busy0, 19);
      chk("b2b load2", c_load, 20);
      chk("b2b done2", c_done2, 37);
      $display("seq b2b done1=%0d idle=%0d load2=%0d done2=%0d", c_done, c_busy0, c_load, c_done2);
      repeat (4) @(negedge Clk);
      chk("b2b settled", 32'(busy[0]), 0);

`ifdef MULT_CTRL_DONE_HOLD_EN
      // Done held while Ack is withheld; St held restarts after one IDLE cycle.
      ack[0] = 1'b0;
      mult_val[0] = 32'h05;
      @(negedge Clk);
      st[0] = 1'b1;
      @(posedge Clk);
      c_done = -1; dcount = 0; c_fall = -1; c_busy0 = -1; c_load2 = -1;
      for (int cyc = 1; cyc <= 80 && c_load2 < 0; cyc++) begin
         @(negedge Clk);
         if (done[0]) begin
            if (c_done < 0) c_done = cyc;
            dcount++;
            if (dcount == 6) ack[0] = 1'b1;
         end else if (c_done > 0 && c_fall < 0) begin
            c_fall = cyc;
            if (!busy[0]) c_busy0 = cyc;
         end else if (c_fall > 0 && load[0]) begin
            c_load2 = cyc;
         end
      end
      st[0] = 1'b0;
      chk("hold done_start", c_done, 20);
      chk("hold done_len", dcount, 6);
      chk("hold done_fall", c_fall, 26);
      chk("hold busy_fall", c_busy0, 26);
      chk("hold next_load", c_load2, 27);
      $display("seq hold done=%0d len=%0d fall=%0d load2=%0d", c_done, dcount, c_fall, c_load2);
      repeat (30) @(negedge Clk);
      chk("hold settled", 32'(busy[0]), 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mult_control.md
MULT_CONTROL -- requirements
Module: mult_control

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the operand width in bits and the number of shift steps per multiply (legal 2..32).
REQ-002 SHALL have port Clk, input, 1, the single system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have port St, input, 1, start request, sampled in IDLE only.
REQ-005 SHALL have port LSB, input, 1, current multiplier LSB from the datapath.
REQ-006 SHALL have port Ack, input, 1, result acknowledge; used only when MULT_CTRL_DONE_HOLD_EN is defined.
REQ-007 SHALL have port Load, output, 1, datapath load strobe for operands and the accumulator clear.
REQ-008 SHALL have port Ad, output, 1, datapath add-enable.
REQ-009 SHALL have port Sh, output, 1, datapath shift-enable.
REQ-010 SHALL have port Done, output, 1, result valid.
REQ-011 SHALL have port Busy, output, 1, high in every state except IDLE.
REQ-012 SHALL have port Cnt, output, clog2(WIDTH)+1, the number of shifts completed in the current operation.

Function
REQ-013 SHALL implement a Moore FSM with the states IDLE, LOAD, CHECK, ADD, SHIFT and DONE; all outputs SHALL be decoded from state and Cnt only.
REQ-014 In IDLE, St=1 SHALL go to LOAD; St=0 SHALL stay in IDLE; St in any other state SHALL be ignored, with no queuing.
REQ-015 LOAD SHALL assert Load=1 for exactly one cycle, clear Cnt to 0, and go to CHECK.
REQ-016 CHECK SHALL go to ADD if LSB=1 and to SHIFT if LSB=0, with Load, Ad and Sh all 0.
REQ-017 ADD SHALL assert Ad=1 for one cycle and go to SHIFT.
REQ-018 SHIFT SHALL assert Sh=1 for one cycle and increment Cnt; when the incremented Cnt equals WIDTH it SHALL go to DONE, otherwise to CHECK.
REQ-019 Cnt SHALL never exceed WIDTH and SHALL hold its value in DONE and IDLE until the next LOAD.
REQ-020 Ad and Sh SHALL never be high in the same cycle; Load SHALL never coincide with either.
REQ-021 Latency: if St is sampled at edge 0, Done SHALL first be high in cycle 2*WIDTH+N1+2, where N1 is the number of LSB=1 observations in CHECK.
REQ-022 St=1 held continuously SHALL start a new operation on the first IDLE cycle, giving back-to-back multiplies with one IDLE cycle between them.

Reset
REQ-023 rst=0 SHALL immediately force IDLE, Cnt=0, Load=Ad=Sh=Done=Busy=0, independent of Clk.
REQ-024 Reset asserted mid-operation SHALL abort with no Done; after rst returns high, the first operation SHALL start only on a new St.
REQ-025 Release of rst SHALL be treated as synchronous to Clk; the first state change SHALL occur on the first rising edge after release.

Configuration
REQ-026 Macro MULT_CTRL_DONE_HOLD_EN undefined: DONE SHALL last exactly one cycle, then go to IDLE; Ack SHALL be ignored.
REQ-027 Macro MULT_CTRL_DONE_HOLD_EN defined: DONE and Done=1 SHALL hold until a cycle with Ack=1 sampled, then go to IDLE on that edge; Ack=1 already present on DONE entry SHALL release DONE after one cycle.

Verification
REQ-028 WIDTH=8, multiplier 0x05, St pulse -> Load once; Ad pulses on CHECK of bits 0 and 2; 8 Sh pulses; Done in cycle 20; Cnt=8.
REQ-029 WIDTH=8, multiplier 0x00 -> no Ad; Done in cycle 18. Multiplier 0xFF -> 8 Ad; Done in cycle 26.
REQ-030 St re-pulsed during SHIFT of bit 3 -> ignored; exactly one Done; Busy falls one cycle after Done.
REQ-031 rst driven low between edges during the ADD of bit 4 -> outputs 0 and IDLE immediately; no Done afterwards without a new St.
REQ-032 MULT_CTRL_DONE_HOLD_EN defined, Ack withheld 5 cycles -> Done held 6 cycles and falls on the edge after Ack=1; St held continuously -> next Load one cycle after Busy falls.
REQ-033 WIDTH=2 and WIDTH=32 with a random multiplier -> latency per REQ-021; Cnt ends at WIDTH.
